// File: rtl/branch_update_scheduler.sv
// -----------------------------------------------------------------------------
// branch_update_scheduler
//
// Collects committed-branch counter updates from a 2-wide commit stage into a
// small FIFO and replays them to the local predictor's single update port,
// one update per cycle, oldest first (slot 0 before slot 1 within a cycle).
//
// Optional build macro:
//   UPD_FWD_EN  - when defined, an issue whose PC matches the update issued in
//                 the immediately preceding cycle uses that update's saturated
//                 next value instead of its own (stale) snapshot.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   PC_W   branch PC index width
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   cm0_* / cm1_*              commit slots (slot 1 is younger than slot 0)
//   cm_ready                   high when two or more entries are free
//   flush                      drop everything queued; stop the current pulse
//   CommitedBranchPC           issued update PC          (registered)
//   BranchTaken                issued direction          (registered)
//   BranchCounter              issued counter value      (registered)
//   CounterUpdate              one-cycle pulse per issued update (registered)
// -----------------------------------------------------------------------------
module branch_update_scheduler #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 10
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cm0_valid,
  input  logic [PC_W-1:0] cm0_pc,
  input  logic            cm0_taken,
  input  logic [1:0]      cm0_counter,
  input  logic            cm1_valid,
  input  logic [PC_W-1:0] cm1_pc,
  input  logic            cm1_taken,
  input  logic [1:0]      cm1_counter,
  output logic            cm_ready,
  input  logic            flush,
  output logic [PC_W-1:0] CommitedBranchPC,
  output logic            BranchTaken,
  output logic [1:0]      BranchCounter,
  output logic            CounterUpdate
);

  localparam int DEPTH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = DEPTH_W + 1;
  // Largest occupancy that still leaves room for a full 2-wide commit.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  // Saturating 2-bit counter step.
  function automatic logic [1:0] satNext(input logic [1:0] c, input logic t);
    logic [1:0] r;
    r = c;
    if (t) begin
      if (c != 2'd3) r = c + 2'd1;
    end else begin
      if (c != 2'd0) r = c - 2'd1;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Queue storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]    pcMem    [DEPTH];
  logic               takenMem [DEPTH];
  logic [1:0]         cntMem   [DEPTH];

  logic [DEPTH_W-1:0] wrPtrReg, wrPtrNext;
  logic [DEPTH_W-1:0] rdPtrReg, rdPtrNext;
  logic [CNT_W-1:0]   countReg, countNext;

  logic               enq0, enq1, deq;
  logic [DEPTH_W-1:0] addr0, addr1;

  logic [PC_W-1:0]    headPc;
  logic               headTaken;
  logic [1:0]         headCnt;
  logic [1:0]         issueCounter;

  assign cm_ready = (countReg <= READY_MAX);

  // Commits in a flush cycle are dropped along with the queue contents.
  assign enq0 = cm0_valid & cm_ready & ~flush;
  assign enq1 = cm1_valid & cm_ready & ~flush;
  // Decided from the registered count, so a same-cycle enqueue is never
  // dequeued before the next edge.
  assign deq  = (countReg != '0);

  // Slot 1 packs directly behind slot 0, or takes the tail slot itself when
  // slot 0 is empty.
  assign addr0 = wrPtrReg;
  assign addr1 = wrPtrReg + DEPTH_W'(enq0);

  assign headPc    = pcMem[rdPtrReg];
  assign headTaken = takenMem[rdPtrReg];
  assign headCnt   = cntMem[rdPtrReg];

  always_comb begin
    wrPtrNext = wrPtrReg + DEPTH_W'(enq0) + DEPTH_W'(enq1);
    rdPtrNext = rdPtrReg + DEPTH_W'(deq);
    countNext = countReg + CNT_W'(enq0) + CNT_W'(enq1) - CNT_W'(deq);
    if (flush) begin
      wrPtrNext = '0;
      rdPtrNext = '0;
      countNext = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      wrPtrReg <= wrPtrNext;
      rdPtrReg <= rdPtrNext;
      countReg <= countNext;
    end
  end

  // Per-entry write. The two slot addresses never collide when both slots
  // enqueue, so each entry has at most one source per cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      logic hit0, hit1;
      assign hit0 = enq0 && (addr0 == DEPTH_W'(gi));
      assign hit1 = enq1 && (addr1 == DEPTH_W'(gi));
      always_ff @(posedge clk) begin
        if (hit1) begin
          pcMem[gi]    <= cm1_pc;
          takenMem[gi] <= cm1_taken;
          cntMem[gi]   <= cm1_counter;
        end else if (hit0) begin
          pcMem[gi]    <= cm0_pc;
          takenMem[gi] <= cm0_taken;
          cntMem[gi]   <= cm0_counter;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Counter forwarding between back-to-back issues of the same PC
  // ---------------------------------------------------------------------------
`ifdef UPD_FWD_EN
  logic            fwdValidReg;
  logic [PC_W-1:0] fwdPcReg;
  logic [1:0]      fwdCntReg;

  // The predictor table has not absorbed the previous update when the next
  // one for the same PC was snapshotted, so the snapshot may be stale.
  assign issueCounter = (fwdValidReg && (fwdPcReg == headPc)) ? fwdCntReg : headCnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fwdValidReg <= 1'b0;
      fwdPcReg    <= '0;
      fwdCntReg   <= '0;
    end else if (flush) begin
      fwdValidReg <= 1'b0;
    end else if (deq) begin
      fwdValidReg <= 1'b1;
      fwdPcReg    <= headPc;
      fwdCntReg   <= satNext(issueCounter, headTaken);
    end else begin
      // A gap cycle lets the table catch up, so the forward is no longer needed.
      fwdValidReg <= 1'b0;
    end
  end
`else
  assign issueCounter = headCnt;
`endif

  // ---------------------------------------------------------------------------
  // Issue registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      CommitedBranchPC <= '0;
      BranchTaken      <= 1'b0;
      BranchCounter    <= 2'd0;
      CounterUpdate    <= 1'b0;
    end else if (flush) begin
      // Only the pulse is squashed; the data outputs keep their last value.
      CounterUpdate <= 1'b0;
    end else if (deq) begin
      CommitedBranchPC <= headPc;
      BranchTaken      <= headTaken;
      BranchCounter    <= issueCounter;
      CounterUpdate    <= 1'b1;
    end else begin
      CounterUpdate <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_update_scheduler.sv
module tb_branch_update_scheduler;

  localparam int PC_W = 10;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            t;
    logic [1:0]      c;
  } ent_t;

  typedef struct packed {
    logic v0;
    ent_t e0;
    logic v1;
    ent_t e1;
  } pair_t;

  logic            clk;
  logic            rstn;
  logic            cm0_valid, cm1_valid;
  logic [PC_W-1:0] cm0_pc, cm1_pc;
  logic            cm0_taken, cm1_taken;
  logic [1:0]      cm0_counter, cm1_counter;
  logic            cm_ready;
  logic            flush;
  logic [PC_W-1:0] CommitedBranchPC;
  logic            BranchTaken;
  logic [1:0]      BranchCounter;
  logic            CounterUpdate;

  int compared   = 0;
  int mismatched = 0;

  pair_t stim[$];
  ent_t  expQ[$];
  logic  sawBusy;

  branch_update_scheduler #(.DEPTH(4), .PC_W(PC_W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .cm0_valid       (cm0_valid),
    .cm0_pc          (cm0_pc),
    .cm0_taken       (cm0_taken),
    .cm0_counter     (cm0_counter),
    .cm1_valid       (cm1_valid),
    .cm1_pc          (cm1_pc),
    .cm1_taken       (cm1_taken),
    .cm1_counter     (cm1_counter),
    .cm_ready        (cm_ready),
    .flush           (flush),
    .CommitedBranchPC(CommitedBranchPC),
    .BranchTaken     (BranchTaken),
    .BranchCounter   (BranchCounter),
    .CounterUpdate   (CounterUpdate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input pair_t p);
    cm0_valid = p.v0; cm0_pc = p.e0.pc; cm0_taken = p.e0.t; cm0_counter = p.e0.c;
    cm1_valid = p.v1; cm1_pc = p.e1.pc; cm1_taken = p.e1.t; cm1_counter = p.e1.c;
  endtask

  task automatic idle();
    pair_t z;
    z = '0;
    drive(z);
  endtask

  // Queue a commit pair and the updates it must produce, in commit order.
  task automatic addPair(input logic v0, input ent_t e0, input logic v1, input ent_t e1);
    pair_t p;
    p.v0 = v0; p.e0 = e0; p.v1 = v1; p.e1 = e1;
    stim.push_back(p);
    if (v0) expQ.push_back(e0);
    if (v1) expQ.push_back(e1);
  endtask

  // Present stim pairs (held while cm_ready=0) and compare every issue
  // against expQ; bounded by a cycle budget.
  task automatic runTraffic(input string tag);
    int   cyc;
    logic acc;
    ent_t e;
    ent_t got;
    cyc = 0;
    while ((stim.size() > 0 || expQ.size() > 0) && cyc < 100) begin
      if (stim.size() > 0) drive(stim[0]); else idle();
      acc = cm_ready;
      if (!cm_ready) sawBusy = 1'b1;
      tick();
      if (acc && stim.size() > 0) void'(stim.pop_front());
      if (CounterUpdate) begin
        got = '{pc: CommitedBranchPC, t: BranchTaken, c: BranchCounter};
        $display("%s issue pc=%h taken=%0d counter=%0d", tag, got.pc, got.t, got.c);
        if (expQ.size() == 0) begin
          chk({tag, "_extra"}, 32'(got), 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          chk({tag, "_issue"}, 32'(got), 32'(e));
        end
      end
      cyc++;
    end
    idle();
    chk({tag, "_drained"}, 32'(expQ.size() + stim.size()), 32'd0);
    stim.delete();
    expQ.delete();
    tick();
    chk({tag, "_quiet"}, 32'(CounterUpdate), 32'd0);
    chk({tag, "_ready"}, 32'(cm_ready), 32'd1);
  endtask

  initial begin
    ent_t  a, b;
    logic [5:0] v0pat, v1pat;
    logic  anyUpd;

    rstn = 1'b1; flush = 1'b0; sawBusy = 1'b0;
    idle();

    // ---------------- reset state ----------------
    #2 rstn = 1'b0;
    #1;
    chk("rst_upd",   32'(CounterUpdate),    32'd0);
    chk("rst_pc",    32'(CommitedBranchPC), 32'd0);
    chk("rst_cnt",   32'(BranchCounter),    32'd0);
    chk("rst_ready", 32'(cm_ready),         32'd1);
    tick(); tick();
    rstn = 1'b1;
    tick();
    $display("reset released");

    // ---------------- single commit latency ----------------
    cm0_valid = 1'b1; cm0_pc = 10'h005; cm0_taken = 1'b1; cm0_counter = 2'b01;
    tick();
    idle();
    chk("lat_n1_upd", 32'(CounterUpdate), 32'd0);
    tick();
    $display("single issue pc=%h taken=%0d counter=%0d", CommitedBranchPC, BranchTaken, BranchCounter);
    chk("lat_n2_upd",   32'(CounterUpdate),    32'd1);
    chk("lat_n2_pc",    32'(CommitedBranchPC), 32'h005);
    chk("lat_n2_taken", 32'(BranchTaken),      32'd1);
    chk("lat_n2_cnt",   32'(BranchCounter),    32'd1);
    tick();
    chk("lat_n3_upd", 32'(CounterUpdate), 32'd0);

    // ---------------- dual-commit burst ----------------
    sawBusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = '{pc: PC_W'(10'h100 + 2*i), t: 1'b0, c: 2'(i)};
      b = '{pc: PC_W'(10'h101 + 2*i), t: 1'b1, c: 2'(3 - i)};
      addPair(1'b1, a, 1'b1, b);
    end
    runTraffic("burst");
    chk("burst_backpressure", 32'(sawBusy), 32'd1);

    // ---------------- slot1-only and pointer wrap ----------------
    v0pat = 6'b101110;
    v1pat = 6'b111011;
    for (int i = 0; i < 6; i++) begin
      a = '{pc: PC_W'(10'h200 + 2*i), t: 1'b1, c: 2'd3};
      b = '{pc: (i == 0) ? 10'h3FF : PC_W'(10'h201 + 2*i), t: 1'b0, c: 2'd0};
      addPair(v0pat[i], a, v1pat[i], b);
    end
    runTraffic("wrap");

    // ---------------- back-to-back same PC ----------------
    a = '{pc: 10'h010, t: 1'b1, c: 2'b10};
    b = '{pc: 10'h010, t: 1'b1, c: 2'b10};
    stim.push_back('{v0: 1'b1, e0: a, v1: 1'b1, e1: b});
    expQ.push_back(a);
`ifdef UPD_FWD_EN
    b.c = 2'b11;
`endif
    expQ.push_back(b);
    runTraffic("samepc");

    // ---------------- flush with 3 queued plus a commit ----------------
    drive('{v0: 1'b1, e0: '{pc: 10'h020, t: 1'b1, c: 2'd1},
            v1: 1'b1, e1: '{pc: 10'h021, t: 1'b0, c: 2'd2}});
    tick();
    drive('{v0: 1'b1, e0: '{pc: 10'h022, t: 1'b1, c: 2'd1},
            v1: 1'b1, e1: '{pc: 10'h023, t: 1'b0, c: 2'd2}});
    tick();
    chk("fl_pre_ready", 32'(cm_ready),         32'd0);
    chk("fl_pre_upd",   32'(CounterUpdate),    32'd1);
    chk("fl_pre_pc",    32'(CommitedBranchPC), 32'h020);
    drive('{v0: 1'b1, e0: '{pc: 10'h030, t: 1'b1, c: 2'd0}, v1: 1'b0, e1: '0});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    $display("flush done upd=%0d ready=%0d", CounterUpdate, cm_ready);
    chk("fl_upd",     32'(CounterUpdate),    32'd0);
    chk("fl_ready",   32'(cm_ready),         32'd1);
    chk("fl_pc_hold", 32'(CommitedBranchPC), 32'h020);
    anyUpd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      anyUpd = anyUpd | CounterUpdate;
    end
    chk("fl_nothing_issued", 32'(anyUpd), 32'd0);

    // ---------------- reset mid-burst ----------------
    drive('{v0: 1'b1, e0: '{pc: 10'h040, t: 1'b1, c: 2'd2},
            v1: 1'b1, e1: '{pc: 10'h041, t: 1'b1, c: 2'd2}});
    tick();
    drive('{v0: 1'b1, e0: '{pc: 10'h042, t: 1'b0, c: 2'd1},
            v1: 1'b1, e1: '{pc: 10'h043, t: 1'b0, c: 2'd1}});
    tick();
    chk("mr_pre_upd", 32'(CounterUpdate), 32'd1);
    #2 rstn = 1'b0;
    #1;
    idle();
    $display("mid-burst reset upd=%0d pc=%h", CounterUpdate, CommitedBranchPC);
    chk("mr_upd",   32'(CounterUpdate),    32'd0);
    chk("mr_pc",    32'(CommitedBranchPC), 32'd0);
    chk("mr_taken", 32'(BranchTaken),      32'd0);
    chk("mr_ready", 32'(cm_ready),         32'd1);
    tick();
    rstn = 1'b1;
    anyUpd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      anyUpd = anyUpd | CounterUpdate;
    end
    chk("mr_empty_after", 32'(anyUpd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
